vga_ctrl: RTL and testbench

VGA_CTRL -- requirements
Module: vga_ctrl

---
 rtl/vga_ctrl_if.sv | 22 ++
 rtl/vga_ctrl.sv | 74 +++++++
 tb/tb_vga_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_ctrl_if.sv
// Video bus between the VGA timing controller, the image generator and the
// DAC side: pixel requests out, pixel data in, syncs and active video out.
interface vga_ctrl_if;
   logic [23:0] pix_data;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic        hsync;
   logic        vsync;
   logic        de;
   logic [23:0] rgb;
   logic        frame_start;

   modport master (
      input  pix_data,
      output pix_x, pix_y, hsync, vsync, de, rgb, frame_start
   );

   modport slave (
      output pix_data,
      input  pix_x, pix_y, hsync, vsync, de, rgb, frame_start
   );
endinterface

// File: rtl/vga_ctrl.sv
// VGA timing generator: free-running h/v counters with all outputs decoded
// straight from the registered counts; pixel requests lead de by one cycle.
module vga_ctrl #(
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 40,
   parameter int H_LEFT   = 8,
   parameter int H_VALID  = 640,
   parameter int H_RIGHT  = 8,
   parameter int H_FRONT  = 8,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 25,
   parameter int V_TOP    = 8,
   parameter int V_VALID  = 480,
   parameter int V_BOTTOM = 8,
   parameter int V_FRONT  = 2
) (
   input  logic       vga_clk,
   input  logic       sys_rst_n,
   vga_ctrl_if.master vga
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID
                          + H_RIGHT + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID
                          + V_BOTTOM + V_FRONT;
   localparam int H_START = H_SYNC + H_BACK + H_LEFT;
   localparam int V_START = V_SYNC + V_BACK + V_TOP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] HS_END   = 10'(H_SYNC - 1);
   localparam logic [9:0] VS_END   = 10'(V_SYNC - 1);
   localparam logic [9:0] H_ST     = 10'(H_START);
   localparam logic [9:0] H_END    = 10'(H_START + H_VALID);
   localparam logic [9:0] H_RQ     = 10'(H_START - 1);
   localparam logic [9:0] H_RQ_END = 10'(H_START + H_VALID - 1);
   localparam logic [9:0] V_ST     = 10'(V_START);
   localparam logic [9:0] V_END    = 10'(V_START + V_VALID);

   logic [9:0] cnt_h;
   logic [9:0] cnt_v;
   logic       h_act;
   logic       h_req;
   logic       v_act;

   // Line and frame wrap happen in the same cycle, so no line is skipped.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_h <= '0;
         cnt_v <= '0;
      end else if (cnt_h == H_LAST) begin
         cnt_h <= '0;
         cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + 10'd1;
      end else begin
         cnt_h <= cnt_h + 10'd1;
      end
   end

   assign h_act = (cnt_h >= H_ST) && (cnt_h < H_END);
   assign h_req = (cnt_h >= H_RQ) && (cnt_h < H_RQ_END);
   assign v_act = (cnt_v >= V_ST) && (cnt_v < V_END);

   assign vga.hsync       = cnt_h <= HS_END;
   assign vga.vsync       = cnt_v <= VS_END;
   assign vga.de          = h_act && v_act;
   assign vga.frame_start = (cnt_h == '0) && (cnt_v == '0);

   // Requests lead by one cycle to cover the generator's output register.
   assign vga.pix_x = (h_req && v_act) ? cnt_h - H_RQ : 10'h3FF;
   assign vga.pix_y = (h_req && v_act) ? cnt_v - V_ST : 10'h3FF;

   assign vga.rgb = vga.de ? vga.pix_data : 24'h0;

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: a shrunk-timing instance for full-frame checks and a
// default-timing instance for line-level checks of the 640x480 mode.
module tb_vga_ctrl;

   localparam int HS = 4, HB = 3, HL = 2, HV = 10, HR = 2, HF = 3;
   localparam int VS = 2, VB = 2, VTP = 1, VV = 6, VBT = 1, VF = 2;
   localparam int HT = 24, VT = 14, HST = 9, VST = 5;
   localparam int FRAME = HT * VT;

   logic vga_clk = 1'b0;
   logic sys_rst_n = 1'b0;
   always #5 vga_clk = ~vga_clk;

   vga_ctrl_if s_if ();
   vga_ctrl_if d_if ();

   vga_ctrl #(
      .H_SYNC(HS), .H_BACK(HB), .H_LEFT(HL), .H_VALID(HV),
      .H_RIGHT(HR), .H_FRONT(HF),
      .V_SYNC(VS), .V_BACK(VB), .V_TOP(VTP), .V_VALID(VV),
      .V_BOTTOM(VBT), .V_FRONT(VF)
   ) u_small (
      .vga_clk(vga_clk),
      .sys_rst_n(sys_rst_n),
      .vga(s_if)
   );

   vga_ctrl u_def (
      .vga_clk(vga_clk),
      .sys_rst_n(sys_rst_n),
      .vga(d_if)
   );

   typedef struct {
      int          id;
      logic [63:0] val;
   } exp_t;

   typedef struct {
      int         h;
      int         v;
      logic       hs;
      logic       vs;
      logic       de;
      logic [9:0] px;
      logic [9:0] py;
   } vec_t;

   exp_t sbq[$];
   vec_t vt[13];

   int n_tests = 0;
   int n_fail = 0;
   int sh = 0, sv = 0, dh = 0, dv = 0;
   int mode = 0;
   int cyc = 0;
   int white_cnt = 0;
   int de35_cnt = 0;
   logic [9:0] s_px_reg = 10'h3FF;
   logic [9:0] d_px_reg = 10'h3FF;

   int   m_last[3];
   int   m_run[3];
   logic m_prev[3];
   bit   m_seen[3];

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] model(int h, int v, int hsy, int vsy,
                                         int hst, int hva, int vst,
                                         int vva, int md);
      bit hr, va, de;
      logic [9:0] px, py;
      logic [23:0] rgb;
      hr = (h >= hst - 1) && (h < hst + hva - 1);
      va = (v >= vst) && (v < vst + vva);
      de = (h >= hst) && (h < hst + hva) && va;
      px = (hr && va) ? 10'(h - hst + 1) : 10'h3FF;
      py = (hr && va) ? 10'(v - vst) : 10'h3FF;
      rgb = !de ? 24'h0 : (md != 0) ? 24'hFFFFFF : 24'(h - hst);
      return {16'h0, logic'(h < hsy), logic'(v < vsy), de,
              logic'(h == 0 && v == 0), rgb, px, py};
   endfunction

   function automatic void adv(inout int h, inout int v, input int ht,
                               input int vt_);
      if (h == ht - 1) begin
         h = 0;
         v = (v == vt_ - 1) ? 0 : v + 1;
      end else begin
         h = h + 1;
      end
   endfunction

   task automatic push_exp();
      exp_t e;
      e.id = 0;
      e.val = model(sh, sv, HS, VS, HST, HV, VST, VV, mode);
      sbq.push_back(e);
      e.id = 1;
      e.val = model(dh, dv, 96, 2, 144, 640, 35, 480, mode);
      sbq.push_back(e);
   endtask

   task automatic pop_chk();
      exp_t e;
      logic [63:0] act;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         if (e.id == 0)
            act = {16'h0, s_if.hsync, s_if.vsync, s_if.de,
                   s_if.frame_start, s_if.rgb, s_if.pix_x, s_if.pix_y};
         else
            act = {16'h0, d_if.hsync, d_if.vsync, d_if.de,
                   d_if.frame_start, d_if.rgb, d_if.pix_x, d_if.pix_y};
         chk($sformatf("sb%0d h=%0d v=%0d", e.id,
                       e.id == 0 ? sh : dh, e.id == 0 ? sv : dv),
             act, e.val);
      end
   endtask

   task automatic mon_clear();
      for (int i = 0; i < 3; i++) begin
         m_last[i] = -1;
         m_run[i] = 0;
         m_prev[i] = 1'b1;
         m_seen[i] = 1'b0;
      end
   endtask

   task automatic mon(int id, logic sig, int per, int hi, string nm);
      if (sig && !m_prev[id]) begin
         if (m_last[id] >= 0)
            chk({nm, "_period"}, 64'(cyc - m_last[id]), 64'(per));
         m_last[id] = cyc;
         m_seen[id] = 1'b1;
         m_run[id] = 0;
      end
      if (sig) m_run[id]++;
      if (!sig && m_prev[id] && m_seen[id])
         chk({nm, "_high"}, 64'(m_run[id]), 64'(hi));
      m_prev[id] = sig;
   endtask

   task automatic drive();
      s_if.pix_data = (mode != 0) ? 24'hFFFFFF :
                      (s_px_reg == 10'h3FF) ? 24'hA5A5A5 : {14'h0, s_px_reg};
      d_if.pix_data = (mode != 0) ? 24'hFFFFFF :
                      (d_px_reg == 10'h3FF) ? 24'hA5A5A5 : {14'h0, d_px_reg};
   endtask

   task automatic tick();
      logic rs;
      @(posedge vga_clk);
      rs = sys_rst_n;
      #1;
      if (rs) begin
         adv(sh, sv, HT, VT);
         adv(dh, dv, 800, 525);
      end
      drive();
      push_exp();
      @(negedge vga_clk);
      cyc++;
      pop_chk();
      s_px_reg = s_if.pix_x;
      d_px_reg = d_if.pix_x;
      if (sys_rst_n) begin
         if (s_if.rgb == 24'hFFFFFF) white_cnt++;
         mon(0, s_if.frame_start, FRAME, 1, "small_fs");
         mon(1, s_if.vsync, FRAME, VS * HT, "small_vs");
         mon(2, d_if.hsync, 800, 96, "def_hs");
         if (dv == 35 && d_if.de) de35_cnt++;
         if (dv == 35 && (dh == 143 || dh == 782 || dh == 783))
            chk($sformatf("def_l35_px h=%0d", dh), 64'(d_if.pix_x),
                dh == 783 ? 64'h3FF : dh == 143 ? 64'd0 : 64'd639);
      end
   endtask

   task automatic wait_at(int h, int v, string nm);
      int k = 0;
      while (!(sh == h && sv == v) && k < 2 * FRAME) begin
         tick();
         k++;
      end
      if (k >= 2 * FRAME) chk({nm, "_timeout"}, 64'd1, 64'd0);
   endtask

   initial begin
      vt[0]  = '{0, 0, 1'b1, 1'b1, 1'b0, 10'h3FF, 10'h3FF};
      vt[1]  = '{3, 1, 1'b1, 1'b1, 1'b0, 10'h3FF, 10'h3FF};
      vt[2]  = '{4, 2, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF};
      vt[3]  = '{8, 4, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF};
      vt[4]  = '{8, 5, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
      vt[5]  = '{9, 5, 1'b0, 1'b0, 1'b1, 10'd1, 10'd0};
      vt[6]  = '{17, 5, 1'b0, 1'b0, 1'b1, 10'd9, 10'd0};
      vt[7]  = '{18, 5, 1'b0, 1'b0, 1'b1, 10'h3FF, 10'h3FF};
      vt[8]  = '{19, 5, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF};
      vt[9]  = '{12, 10, 1'b0, 1'b0, 1'b1, 10'd4, 10'd5};
      vt[10] = '{12, 11, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF};
      vt[11] = '{23, 13, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF};
      vt[12] = '{9, 0, 1'b0, 1'b1, 1'b0, 10'h3FF, 10'h3FF};

      mon_clear();
      s_if.pix_data = 24'h0;
      d_if.pix_data = 24'h0;
      repeat (3) tick();
      sys_rst_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         wait_at(vt[i].h, vt[i].v, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d", i),
             {41'h0, s_if.hsync, s_if.vsync, s_if.de, s_if.pix_x, s_if.pix_y},
             {41'h0, vt[i].hs, vt[i].vs, vt[i].de, vt[i].px, vt[i].py});
      end

      mode = 1;
      wait_at(0, 0, "white_align");
      white_cnt = 0;
      repeat (FRAME) tick();
      chk("white_count", 64'(white_cnt), 64'(HV * VV));
      mode = 0;

      wait_at(12, 8, "rst_align");
      sys_rst_n = 1'b0;
      #1;
      sh = 0; sv = 0; dh = 0; dv = 0;
      mon_clear();
      push_exp();
      pop_chk();
      repeat (3) tick();
      sys_rst_n = 1'b1;
      begin
         int k = 0;
         do begin
            tick();
            k++;
         end while (!s_if.frame_start && k < 2 * FRAME);
         chk("fs_after_release", 64'(k), 64'(FRAME));
      end

      begin
         int k = 0;
         while (!(dv == 36 && dh == 0) && k < 40000) begin
            tick();
            k++;
         end
         if (k >= 40000) chk("def_run_timeout", 64'd1, 64'd0);
      end
      chk("def_l35_de_count", 64'(de35_cnt), 64'd640);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
